uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
Parametrised, synthesizable UART transmitter with an input byte FIFO. It replaces fixed-format, fixed-timing serial stimulus with a configurable frame engine: data width, parity, stop bits, inter-frame gap and baud divider are all set by parameters. It sits beside the SoC UART, either as a bench/FPGA stimulus source driving uart_rx_pin or as the tx path of a next-generation UART peripheral.

Parameters:
CLK_DIV, 868, clock cycles per serial bit (868 gives 115200 baud at 100 MHz); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; legal values 1 or 2
GAP_BITS, 0, idle bit-times inserted after the stop bits before the next start bit
FIFO_DEPTH, 4, input FIFO entries; must be a power of two, at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  when high, frames may start; when low, no new frame is started
in_valid  in  1  byte offered
in_data  in  DATA_BITS  byte payload; LSB is transmitted first
in_ready  out  1  FIFO can accept a byte (equals not full)
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
tx  out  1  serial line; idles high
busy  out  1  high from the start-bit load until the end of the last gap bit
frame_done  out  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset values (asynchronous, take effect immediately): tx=1, busy=0, frame_done=0, in_ready=1, fifo_level=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Any frame in progress is abandoned with no glitch low on tx.
- FIFO:
  - A push occurs when in_valid && in_ready.
  - in_ready and fifo_level are registered.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, in_ready stays 0 in the cycle a pop occurs and rises the cycle after.
  - Pointers wrap modulo FIFO_DEPTH, with one extra pointer bit used to distinguish full from empty.
- FSM states: IDLE, START, DATA, PAR, STOP, GAP.
  - IDLE -> START when en && FIFO not empty. The FIFO head is popped into a shift register in that same cycle.
  - START -> DATA.
  - DATA -> PAR after DATA_BITS bits if PARITY != 0, otherwise DATA -> STOP.
  - PAR -> STOP.
  - STOP -> GAP after STOP_BITS bits if GAP_BITS > 0, otherwise STOP -> IDLE or directly STOP -> START if the restart condition holds.
  - GAP -> IDLE or directly GAP -> START under the same restart condition.
  - Back-to-back frames therefore have zero idle cycles when GAP_BITS = 0.
- Bit timing:
  - Every bit lasts exactly CLK_DIV cycles.
  - The baud counter runs 0..CLK_DIV-1; a bit ends when the counter equals CLK_DIV-1, then the counter reloads to 0.
  - tx is driven from a register.
- Latency: a push into an empty FIFO while IDLE and en=1 (push at edge N) gives tx=0 after edge N+2.
- Frame line levels:
  - START bit: 0.
  - DATA bits: in_data[0] first, through in_data[DATA_BITS-1].
  - PAR bit: XOR of the data bits for even parity, XNOR for odd parity.
  - STOP and GAP bits: 1.
- en=0 never truncates a frame. The current frame, including its gap, completes; the FSM then holds in IDLE.
- frame_done asserts in the last cycle of the last stop bit, independent of GAP_BITS.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE / PAR_EVEN / PAR_ODD;
  - the FSM state enum;
  - the clog2-derived width constants.
- Sub-module sync_fifo (parametrised by WIDTH and DEPTH, with level output) is reused later by the rx path.
- Elaboration-time assertions reject illegal parameter values.

Test Plan:
1. Reset with rst held for 3 cycles -> tx=1, in_ready=1, fifo_level=0, busy=0. Then release with nothing pushed -> tx stays 1 for 100 cycles.
2. CLK_DIV=4, 8N1, push 0x55 -> tx falls 2 edges after the push. Line sequence, each level held 4 cycles: 0,1,0,1,0,1,0,1,0,1. frame_done pulses at cycle 40 of the frame; busy falls the next cycle.
3. PARITY=1, push 0x07 -> parity bit 1. PARITY=2, push 0x07 -> parity bit 0. PARITY=1 with DATA_BITS=5, push 0x1F -> parity bit 1 and an 8-bit-time frame.
4. FIFO_DEPTH=4, five consecutive pushes while IDLE -> the first is popped on the start edge. fifo_level peaks at 4, in_ready drops to 0, the fifth push completes after the first pop. All five frames are sent back-to-back with no idle cycles.
5. STOP_BITS=2, GAP_BITS=1, two bytes queued -> stop high for 8 cycles, then 4 gap cycles, then the start bit. busy stays high across the gap.
6. Assert rst mid-DATA of frame 1, with 2 bytes queued -> tx=1 in the same cycle and fifo_level=0. After release, no frame is sent. Separately, drop en mid-frame -> the current frame completes and the next queued byte waits until en=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and widths for the UART transmit and receive paths.
package uart_pkg;

    // Parity encodings used by the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Upper bounds of the timing parameters and the counter widths they imply.
    localparam int CLK_DIV_MAX  = 65535;
    localparam int GAP_BITS_MAX = 65535;
    localparam int BAUD_CNT_W   = $clog2(CLK_DIV_MAX + 1);
    localparam int BIT_CNT_W    = $clog2(GAP_BITS_MAX + 1);

    // Frame engine states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_GAP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_stream_fifo.sv
// Synchronous FIFO with registered full/empty/level; shared with the rx path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW    = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two, at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next pointers; full/empty/level are derived from them so they can be registered.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        level_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                   (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_stream.sv
// Parametrised UART transmitter fed from a byte FIFO.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done
);

    if (CLK_DIV < 2 || CLK_DIV > CLK_DIV_MAX) begin : g_bad_clk_div
        $error("uart_tx_stream: CLK_DIV out of range 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_stream: DATA_BITS out of range 5..8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_stream: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (GAP_BITS < 0 || GAP_BITS > GAP_BITS_MAX) begin : g_bad_gap_bits
        $error("uart_tx_stream: GAP_BITS out of range 0..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_stream: FIFO_DEPTH must be a power of two, at least 2");
    end

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0]  DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  GAP_LAST  = BIT_CNT_W'(GAP_BITS - 1);

    tx_state_e               state_q, state_d;
    logic [BAUD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]    fifo_rd_data;
    logic                    start_frame;
    logic                    bit_end;
    logic                    restart;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (start_frame),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_ready = ~fifo_full;

    // Next-state, bit timing and line level; tx/busy/frame_done are registered one cycle behind the state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tx_d         = 1'b1;
        frame_done_d = 1'b0;
        start_frame  = 1'b0;
        bit_end      = (cnt_q == BAUD_LAST);
        restart      = en && !fifo_empty;
        busy_d       = (state_q != ST_IDLE);

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + BAUD_CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                bit_d       = '0;
                start_frame = restart;
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PAR: begin
                tx_d = par_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        frame_done_d = 1'b1;
                        bit_d        = '0;
                        if (GAP_BITS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d     = ST_IDLE;
                            start_frame = restart;
                        end
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        bit_d       = '0;
                        state_d     = ST_IDLE;
                        start_frame = restart;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading the next byte overrides whatever state the frame end chose.
        if (start_frame) begin
            state_d = ST_START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo_rd_data;
            par_d   = (PARITY == PAR_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream across several parameter sets.
module tb_uart_tx_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] en_v       = '1;
    logic [4:0] in_valid_v = '0;
    logic [7:0] data_v [5];
    logic [4:0] in_ready_v, tx_v, busy_v, fd_v;
    logic [2:0] lvl_v [5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: 8N1, 1: even parity, 2: odd parity, 3: 5E1, 4: 8N2 with one gap bit
    uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .in_valid(in_valid_v[0]), .in_data(data_v[0]),
        .in_ready(in_ready_v[0]), .fifo_level(lvl_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .in_valid(in_valid_v[1]), .in_data(data_v[1]),
        .in_ready(in_ready_v[1]), .fifo_level(lvl_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .in_valid(in_valid_v[2]), .in_data(data_v[2]),
        .in_ready(in_ready_v[2]), .fifo_level(lvl_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
    uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .en(en_v[3]), .in_valid(in_valid_v[3]), .in_data(data_v[3][4:0]),
        .in_ready(in_ready_v[3]), .fifo_level(lvl_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .frame_done(fd_v[3]));
    uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .GAP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .en(en_v[4]), .in_valid(in_valid_v[4]), .in_data(data_v[4]),
        .in_ready(in_ready_v[4]), .fifo_level(lvl_v[4]), .tx(tx_v[4]), .busy(busy_v[4]), .frame_done(fd_v[4]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until the FIFO takes it.
    task automatic push(input int u, input logic [7:0] d);
        int n;
        n = 0;
        data_v[u]     = d;
        in_valid_v[u] = 1'b1;
        while (!in_ready_v[u] && n < 200) begin
            step();
            n++;
        end
        chk("push_wait", (n < 200), 1);
        step();
        in_valid_v[u] = 1'b0;
    endtask

    // Check every cycle of a frame; bits[i] is the level of bit-time i (CLK_DIV=4 everywhere).
    task automatic check_frame(input int u, input int nbits, input logic [15:0] bits,
                               input int fd_at, input string tag);
        for (int k = 0; k < nbits * 4; k++) begin
            chk({tag, "_tx"},   tx_v[u],   bits[k / 4]);
            chk({tag, "_busy"}, busy_v[u], 1);
            chk({tag, "_done"}, fd_v[u],   (k == fd_at));
            step();
        end
    endtask

    task automatic count_low(input int u, input int cycles, output int lows);
        lows = 0;
        for (int k = 0; k < cycles; k++) begin
            if (tx_v[u] !== 1'b1) lows++;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lows;
        logic [7:0] q4 [5];
        q4[0] = 8'h11; q4[1] = 8'h22; q4[2] = 8'h33; q4[3] = 8'h44; q4[4] = 8'h55;
        for (int i = 0; i < 5; i++) data_v[i] = '0;

        // Reset held for three cycles, then idle line.
        #1;
        repeat (3) step();
        chk("rst_tx",       tx_v,       5'b11111);
        chk("rst_in_ready", in_ready_v, 5'b11111);
        chk("rst_level",    lvl_v[0],   0);
        chk("rst_busy",     busy_v,     0);
        chk("rst_done",     fd_v,       0);
        rst = 1'b0;
        count_low(0, 100, lows);
        chk("idle_tx_low_cycles", lows, 0);

        // 8N1 0x55: tx falls two edges after the push.
        push(0, 8'h55);
        chk("t2_level_after_push", lvl_v[0], 1);
        chk("t2_tx_edge0", tx_v[0], 1);
        step();
        chk("t2_tx_edge1", tx_v[0], 1);
        chk("t2_level_after_pop", lvl_v[0], 0);
        step();
        check_frame(0, 10, {6'b0, 1'b1, 8'h55, 1'b0}, 39, "t2");
        chk("t2_busy_fall", busy_v[0], 0);
        chk("t2_tx_idle",   tx_v[0],   1);

        // Parity: even 0x07 -> 1, odd 0x07 -> 0, 5E1 0x1F -> 1.
        push(1, 8'h07); step(); step();
        check_frame(1, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 43, "even");
        chk("even_busy_fall", busy_v[1], 0);
        push(2, 8'h07); step(); step();
        check_frame(2, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 43, "odd");
        chk("odd_busy_fall", busy_v[2], 0);
        push(3, 8'h1F); step(); step();
        check_frame(3, 8, {8'b0, 1'b1, 1'b1, 5'h1F, 1'b0}, 31, "d5");
        chk("d5_busy_fall", busy_v[3], 0);

        // Fill FIFO with en low, then five frames back-to-back.
        en_v[0] = 1'b0;
        for (int i = 0; i < 4; i++) push(0, q4[i]);
        chk("t4_level_full", lvl_v[0],      4);
        chk("t4_ready_full", in_ready_v[0], 0);
        en_v[0]       = 1'b1;
        data_v[0]     = q4[4];
        in_valid_v[0] = 1'b1;
        step();
        chk("t4_level_after_pop", lvl_v[0],      3);
        chk("t4_ready_after_pop", in_ready_v[0], 1);
        step();
        in_valid_v[0] = 1'b0;
        chk("t4_level_refill", lvl_v[0],      4);
        chk("t4_ready_refill", in_ready_v[0], 0);
        for (int i = 0; i < 5; i++) check_frame(0, 10, {6'b0, 1'b1, q4[i], 1'b0}, 39, "t4");
        chk("t4_busy_fall", busy_v[0], 0);
        chk("t4_level_end", lvl_v[0],  0);

        // Two stop bits plus one gap bit, two queued bytes.
        en_v[4] = 1'b0;
        push(4, 8'hA3);
        push(4, 8'h3C);
        en_v[4] = 1'b1;
        step(); step();
        check_frame(4, 12, {4'b0, 3'b111, 8'hA3, 1'b0}, 43, "g1");
        check_frame(4, 12, {4'b0, 3'b111, 8'h3C, 1'b0}, 43, "g2");
        chk("g_busy_fall", busy_v[4], 0);

        // Reset mid-DATA with two bytes still queued.
        en_v[0] = 1'b0;
        push(0, 8'h5A); push(0, 8'hA5); push(0, 8'hC3);
        en_v[0] = 1'b1;
        step(); step();
        repeat (14) step();
        chk("t6_pre_tx", tx_v[0], 0);
        chk("t6_pre_level", lvl_v[0], 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_tx",    tx_v[0],       1);
        chk("t6_rst_level", lvl_v[0],      0);
        chk("t6_rst_busy",  busy_v[0],     0);
        chk("t6_rst_ready", in_ready_v[0], 1);
        step(); step();
        rst = 1'b0;
        count_low(0, 60, lows);
        chk("t6_post_rst_low_cycles", lows, 0);
        chk("t6_post_rst_busy", busy_v[0], 0);

        // en dropped mid-frame: frame completes, next byte waits.
        en_v[0] = 1'b0;
        push(0, 8'h0F); push(0, 8'hF0);
        en_v[0] = 1'b1;
        step(); step();
        en_v[0] = 1'b0;
        check_frame(0, 10, {6'b0, 1'b1, 8'h0F, 1'b0}, 39, "en1");
        chk("en_busy_fall", busy_v[0], 0);
        count_low(0, 20, lows);
        chk("en_hold_low_cycles", lows, 0);
        chk("en_hold_level", lvl_v[0], 1);
        en_v[0] = 1'b1;
        step();
        chk("en_resume_tx", tx_v[0], 1);
        step();
        check_frame(0, 10, {6'b0, 1'b1, 8'hF0, 1'b0}, 39, "en2");
        chk("en2_busy_fall", busy_v[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
